ppu_chan_master: RTL and testbench

- Synchronous PPU-side bus-cycle sequencer for the 1801VP1-095 CPU/PPU channel.
- Converts simple local byte commands (read/write CSR or DATA) into correctly ordered PPU QBUS strobes toward the channel: nADP address, nSYNCP, nA1P, nWWP/nRDP.
- Autonomously polls the channel CSR and flags changes to PPU firmware/logic.
- Drives nINITP on request.

---
 rtl/ppu_chan_pkg.sv | 22 ++
 rtl/ppu_chan_timer.sv | 29 ++
 rtl/ppu_chan_master.sv | 243 ++++++++++++++++++++++++
 tb/tb_ppu_chan_master.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_chan_pkg.sv
// Shared definitions for the PPU-side channel bus sequencer.
package ppu_chan_pkg;

    // Sequencer states.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_INIT = 3'd1;
    localparam state_t ST_ADDR = 3'd2;
    localparam state_t ST_SYNC = 3'd3;
    localparam state_t ST_GAP  = 3'd4;
    localparam state_t ST_STRB = 3'd5;
    localparam state_t ST_HOLD = 3'd6;
    localparam state_t ST_END  = 3'd7;

    // Register select as seen on A1 (CSR at even word, DATA at odd word).
    localparam logic SEL_CSR = 1'b0;
    localparam logic SEL_DAT = 1'b1;

    // Channel byte address of the 1801VP1-095 CSR/DATA pair.
    localparam logic [7:0] BASE_DEFAULT = 8'o274;

endpackage

// File: rtl/ppu_chan_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
module ppu_chan_timer #(
    parameter int            W       = 8,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_reg;

    // Load has priority over decrement; the count parks at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= RST_VAL;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/ppu_chan_master.sv
// PPU-side bus-cycle sequencer for the CPU/PPU channel: turns local byte
// commands into ordered nADP/nSYNCP/nA1P/nWWP/nRDP cycles, polls the CSR
// in the background and issues nINITP pulses on request.
module ppu_chan_master import ppu_chan_pkg::*; #(
    parameter logic [7:0] BASE     = BASE_DEFAULT,
    parameter int         T_AS     = 2,
    parameter int         T_DS     = 1,
    parameter int         T_STB    = 3,
    parameter int         POLL_DIV = 64,
    parameter int         INIT_LEN = 8
) (
    input  logic       PIN_CLK,
    input  logic       PIN_nRST,
    inout  wire  [7:0] PIN_nADP,
    output logic       PIN_nSYNCP,
    output logic       PIN_nA1P,
    output logic       PIN_nWWP,
    output logic       PIN_nRDP,
    output logic       PIN_nINITP,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_we,
    input  logic       cmd_sel,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    input  logic       poll_en,
    output logic [7:0] csr_q,
    output logic       csr_chg,
    input  logic       init_req,
    output logic       busy
);

    localparam logic [7:0] ADDR_CSR = {BASE[7:2], SEL_CSR, BASE[0]};
    localparam logic [7:0] ADDR_DAT = {BASE[7:2], SEL_DAT, BASE[0]};

    state_t     state_reg, state_next;
    logic       txn_we_reg, txn_we_next;
    logic       txn_sel_reg, txn_sel_next;
    logic       txn_poll_reg, txn_poll_next;
    logic [7:0] txn_wdata_reg, txn_wdata_next;
    logic       pend_reg, pend_next;

    logic [7:0] ad_reg, ad_next;
    logic       nsync_reg, nsync_next;
    logic       na1_reg, na1_next;
    logic       nww_reg, nww_next;
    logic       nrd_reg, nrd_next;
    logic       ninit_reg, ninit_next;
    logic       cmd_ready_reg, rsp_valid_reg, csr_chg_reg, busy_reg;
    logic [7:0] rsp_rdata_reg, csr_q_reg;

    logic       accept, txn_start, sample_edge, cmd_read_done;
    logic       phase_load, phase_zero, poll_load, poll_dec, poll_zero;
    logic [7:0] phase_val;
    logic [7:0] bus_in;

    // The bus is inverted on the wire; a released (pulled-up) bit reads 0.
    assign bus_in = ~PIN_nADP;
    assign accept = cmd_valid & cmd_ready_reg;

    // Next-state logic and transaction capture.
    always_comb begin
        state_next     = state_reg;
        txn_we_next    = txn_we_reg;
        txn_sel_next   = txn_sel_reg;
        txn_poll_next  = txn_poll_reg;
        txn_wdata_next = txn_wdata_reg;
        pend_next      = pend_reg;
        case (state_reg)
            ST_IDLE: begin
                if (init_req) begin
                    // A command accepted alongside init is parked and run after it.
                    state_next = ST_INIT;
                    if (accept) begin
                        txn_we_next    = cmd_we;
                        txn_sel_next   = cmd_sel;
                        txn_wdata_next = cmd_wdata;
                        txn_poll_next  = 1'b0;
                        pend_next      = 1'b1;
                    end
                end else if (pend_reg) begin
                    state_next = ST_ADDR;
                    pend_next  = 1'b0;
                end else if (accept) begin
                    state_next     = ST_ADDR;
                    txn_we_next    = cmd_we;
                    txn_sel_next   = cmd_sel;
                    txn_wdata_next = cmd_wdata;
                    txn_poll_next  = 1'b0;
                end else if (poll_en && poll_zero) begin
                    state_next     = ST_ADDR;
                    txn_we_next    = 1'b0;
                    txn_sel_next   = SEL_CSR;
                    txn_wdata_next = 8'h00;
                    txn_poll_next  = 1'b1;
                end
            end
            ST_INIT: if (phase_zero) state_next = ST_IDLE;
            ST_ADDR: if (phase_zero) state_next = ST_SYNC;
            ST_SYNC: state_next = ST_GAP;
            ST_GAP:  if (phase_zero) state_next = ST_STRB;
            ST_STRB: if (phase_zero) state_next = ST_HOLD;
            ST_HOLD: state_next = ST_END;
            default: state_next = ST_IDLE;
        endcase
    end

    // Reload the phase timer on entry to every multi-clock phase.
    always_comb begin
        phase_load = 1'b0;
        phase_val  = 8'd0;
        if (state_next != state_reg) begin
            case (state_next)
                ST_INIT: begin phase_load = 1'b1; phase_val = 8'(INIT_LEN - 1); end
                ST_ADDR: begin phase_load = 1'b1; phase_val = 8'(T_AS - 1);     end
                ST_GAP:  begin phase_load = 1'b1; phase_val = 8'(T_DS - 1);     end
                ST_STRB: begin phase_load = 1'b1; phase_val = 8'(T_STB - 1);    end
                default: begin phase_load = 1'b0; phase_val = 8'd0;             end
            endcase
        end
    end

    // Pin values for the coming clock, decoded from the state being entered.
    always_comb begin
        ad_next    = 8'h00;
        nsync_next = 1'b1;
        na1_next   = 1'b1;
        nww_next   = 1'b1;
        nrd_next   = 1'b1;
        ninit_next = 1'b1;
        case (state_next)
            ST_INIT: ninit_next = 1'b0;
            ST_ADDR: begin
                ad_next  = txn_sel_next ? ADDR_DAT : ADDR_CSR;
                na1_next = ~txn_sel_next;
            end
            ST_SYNC: begin
                ad_next    = txn_sel_next ? ADDR_DAT : ADDR_CSR;
                na1_next   = ~txn_sel_next;
                nsync_next = 1'b0;
            end
            ST_GAP, ST_HOLD: begin
                ad_next    = txn_we_next ? txn_wdata_next : 8'h00;
                na1_next   = ~txn_sel_next;
                nsync_next = 1'b0;
            end
            ST_STRB: begin
                ad_next    = txn_we_next ? txn_wdata_next : 8'h00;
                na1_next   = ~txn_sel_next;
                nsync_next = 1'b0;
                nww_next   = ~txn_we_next;
                nrd_next   = txn_we_next;
            end
            ST_END:  na1_next = ~txn_sel_next;
            default: ad_next = 8'h00;
        endcase
    end

    assign txn_start     = (state_reg == ST_IDLE) && (state_next != ST_IDLE);
    assign sample_edge   = (state_reg == ST_STRB) && (state_next == ST_HOLD);
    assign cmd_read_done = sample_edge && !txn_poll_reg && !txn_we_reg;
    assign poll_load     = txn_start || !poll_en;
    assign poll_dec      = (state_reg == ST_IDLE) && poll_en;

    ppu_chan_timer #(.W(8), .RST_VAL(8'd0)) u_phase (
        .clk(PIN_CLK), .rst_n(PIN_nRST), .load(phase_load),
        .load_val(phase_val), .dec(!phase_load), .zero(phase_zero)
    );

    // Counts down the idle clocks left before a poll; a full count means
    // no idle clocks seen yet.
    ppu_chan_timer #(.W(16), .RST_VAL(16'(POLL_DIV - 1))) u_poll (
        .clk(PIN_CLK), .rst_n(PIN_nRST), .load(poll_load),
        .load_val(16'(POLL_DIV - 1)), .dec(poll_dec), .zero(poll_zero)
    );

    // State, captured command and all registered outputs.
    always_ff @(posedge PIN_CLK or negedge PIN_nRST) begin
        if (!PIN_nRST) begin
            state_reg     <= ST_IDLE;
            txn_we_reg    <= 1'b0;
            txn_sel_reg   <= SEL_CSR;
            txn_poll_reg  <= 1'b0;
            txn_wdata_reg <= 8'h00;
            pend_reg      <= 1'b0;
            ad_reg        <= 8'h00;
            nsync_reg     <= 1'b1;
            na1_reg       <= 1'b1;
            nww_reg       <= 1'b1;
            nrd_reg       <= 1'b1;
            ninit_reg     <= 1'b1;
            cmd_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 8'h00;
            csr_q_reg     <= 8'h00;
            csr_chg_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            txn_we_reg    <= txn_we_next;
            txn_sel_reg   <= txn_sel_next;
            txn_poll_reg  <= txn_poll_next;
            txn_wdata_reg <= txn_wdata_next;
            pend_reg      <= pend_next;
            ad_reg        <= ad_next;
            nsync_reg     <= nsync_next;
            na1_reg       <= na1_next;
            nww_reg       <= nww_next;
            nrd_reg       <= nrd_next;
            ninit_reg     <= ninit_next;
            busy_reg      <= (state_next != ST_IDLE);
            cmd_ready_reg <= (state_next == ST_IDLE) && !init_req && !pend_next;
            rsp_valid_reg <= cmd_read_done;
            if (cmd_read_done) rsp_rdata_reg <= bus_in;
            csr_chg_reg   <= 1'b0;
            if (sample_edge && txn_poll_reg) begin
                csr_q_reg   <= bus_in;
                csr_chg_reg <= (bus_in != csr_q_reg);
            end else if ((state_reg == ST_INIT) && (state_next == ST_IDLE)) begin
                csr_q_reg <= 8'h00;
            end
        end
    end

    // Open-collector bus: pull a line low where the internal bit is 1.
    for (genvar gi = 0; gi < 8; gi++) begin : g_nadp
        assign PIN_nADP[gi] = ad_reg[gi] ? 1'b0 : 1'bz;
    end

    assign PIN_nSYNCP = nsync_reg;
    assign PIN_nA1P   = na1_reg;
    assign PIN_nWWP   = nww_reg;
    assign PIN_nRDP   = nrd_reg;
    assign PIN_nINITP = ninit_reg;
    assign cmd_ready  = cmd_ready_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_rdata  = rsp_rdata_reg;
    assign csr_q      = csr_q_reg;
    assign csr_chg    = csr_chg_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_ppu_chan_master.sv
// Directed bench for ppu_chan_master: one DUT with default timing
// (POLL_DIV=4) and one with minimum timing, each with a channel-side
// register model answering nRDP on an open-collector, pulled-up bus.
module tb_ppu_chan_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid0 = 1'b0, cmd_valid1 = 1'b0;
    logic       cmd_we = 1'b0, cmd_sel = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       poll_en = 1'b0, init_req = 1'b0;
    logic [7:0] csr_model = 8'h80;
    logic [7:0] data_model = 8'h3C;

    wire  [7:0] nadp0, nadp1;
    logic       nsync0, na10, nww0, nrd0, ninit0, rdy0, rspv0, chg0, busy0;
    logic [7:0] rdata0, csrq0;
    logic       nsync1, na11, nww1, nrd1, ninit1, rdy1, rspv1, chg1, busy1;
    logic [7:0] rdata1, csrq1;
    logic [7:0] model0, model1;

    ppu_chan_master #(.POLL_DIV(4)) dut (
        .PIN_CLK(clk), .PIN_nRST(rst_n), .PIN_nADP(nadp0),
        .PIN_nSYNCP(nsync0), .PIN_nA1P(na10), .PIN_nWWP(nww0), .PIN_nRDP(nrd0),
        .PIN_nINITP(ninit0), .cmd_valid(cmd_valid0), .cmd_ready(rdy0),
        .cmd_we(cmd_we), .cmd_sel(cmd_sel), .cmd_wdata(cmd_wdata),
        .rsp_valid(rspv0), .rsp_rdata(rdata0), .poll_en(poll_en),
        .csr_q(csrq0), .csr_chg(chg0), .init_req(init_req), .busy(busy0)
    );

    ppu_chan_master #(.T_AS(1), .T_DS(1), .T_STB(1)) dut_min (
        .PIN_CLK(clk), .PIN_nRST(rst_n), .PIN_nADP(nadp1),
        .PIN_nSYNCP(nsync1), .PIN_nA1P(na11), .PIN_nWWP(nww1), .PIN_nRDP(nrd1),
        .PIN_nINITP(ninit1), .cmd_valid(cmd_valid1), .cmd_ready(rdy1),
        .cmd_we(cmd_we), .cmd_sel(cmd_sel), .cmd_wdata(cmd_wdata),
        .rsp_valid(rspv1), .rsp_rdata(rdata1), .poll_en(1'b0),
        .csr_q(csrq1), .csr_chg(chg1), .init_req(1'b0), .busy(busy1)
    );

    // Channel model: nA1P high selects CSR, low selects DATA.
    assign model0 = na10 ? csr_model : data_model;
    assign model1 = na11 ? csr_model : data_model;

    for (genvar gi = 0; gi < 8; gi++) begin : g_bus
        pullup pu0 (nadp0[gi]);
        pullup pu1 (nadp1[gi]);
        assign nadp0[gi] = (!nrd0 && model0[gi]) ? 1'b0 : 1'bz;
        assign nadp1[gi] = (!nrd1 && model1[gi]) ? 1'b0 : 1'bz;
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input bit which);
        int n = 0;
        while (!(which ? rdy1 : rdy0) && n < 40) begin
            step();
            n++;
        end
        chk(which ? "rdy_min" : "rdy", {31'd0, which ? rdy1 : rdy0}, 32'd1);
    endtask

    // Waits for a poll to start, then watches its nine clocks.
    task automatic poll_window(input string tag, input logic [7:0] exp_q, input int exp_chg);
        int n = 0;
        int chg = 0;
        int rsp = 0;
        while (!busy0 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_start"}, {31'd0, busy0}, 32'd1);
        for (int k = 0; k < 9; k++) begin
            if (chg0) chg++;
            if (rspv0) rsp++;
            step();
        end
        chk({tag, "_chg"}, chg, exp_chg);
        chk({tag, "_rsp"}, rsp, 0);
        chk({tag, "_csrq"}, {24'd0, csrq0}, {24'd0, exp_q});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int addr_cnt, sync_cnt, ww_cnt, ww_ok, rd_cnt, busy_cnt, rsp_cnt, a1_low, rdy_cnt, init_cnt, chg_cnt;
        int first_s, last_s, first_w, last_w;
        logic [7:0] got_rdata;

        // Reset state.
        step(); step();
        chk("rst_nsync", {31'd0, nsync0}, 1);
        chk("rst_strb", {30'd0, nww0, nrd0}, 32'h3);
        chk("rst_init_a1", {30'd0, ninit0, na10}, 32'h3);
        chk("rst_nadp", {24'd0, nadp0}, 32'hFF);
        chk("rst_ready", {31'd0, rdy0}, 0);
        chk("rst_rsp", {23'd0, rspv0, rdata0}, 0);
        chk("rst_csr", {22'd0, busy0, chg0, csrq0}, 0);
        rst_n = 1'b1;

        // Write DATA 8'hA5 with default timing.
        wait_rdy(0);
        cmd_valid0 = 1'b1; cmd_we = 1'b1; cmd_sel = 1'b1; cmd_wdata = 8'hA5;
        step();
        cmd_valid0 = 1'b0;
        addr_cnt = 0; sync_cnt = 0; ww_cnt = 0; ww_ok = 0; busy_cnt = 0; rsp_cnt = 0; a1_low = 0;
        for (int k = 1; k <= 10; k++) begin
            if (nadp0 == 8'h41) addr_cnt++;
            if (!nsync0) sync_cnt++;
            if (!nww0) ww_cnt++;
            if (!nww0 && nadp0 == 8'h5A) ww_ok++;
            if (busy0) busy_cnt++;
            if (rspv0) rsp_cnt++;
            if (!na10) a1_low++;
            if (k < 10) step();
        end
        chk("wr_addr_clks", addr_cnt, 3);
        chk("wr_sync_clks", sync_cnt, 6);
        chk("wr_strb_clks", ww_cnt, 3);
        chk("wr_strb_data", ww_ok, 3);
        chk("wr_busy_clks", busy_cnt, 9);
        chk("wr_rsp", rsp_cnt, 0);
        chk("wr_a1_low", a1_low, 9);
        chk("wr_ready_back", {31'd0, rdy0}, 1);

        // Read CSR; model returns 8'h80.
        csr_model = 8'h80;
        cmd_valid0 = 1'b1; cmd_we = 1'b0; cmd_sel = 1'b0;
        step();
        cmd_valid0 = 1'b0;
        rd_cnt = 0; rsp_cnt = 0; a1_low = 0; got_rdata = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            if (!nrd0) rd_cnt++;
            if (rspv0) begin rsp_cnt++; got_rdata = rdata0; end
            if (!na10) a1_low++;
            if (k < 10) step();
        end
        chk("rd_strb_clks", rd_cnt, 3);
        chk("rd_rsp_pulses", rsp_cnt, 1);
        chk("rd_rdata", {24'd0, got_rdata}, 32'h80);
        chk("rd_a1_low", a1_low, 0);
        chk("rd_csrq", {24'd0, csrq0}, 0);

        // Background polling.
        poll_en = 1'b1;
        csr_model = 8'h20;
        poll_window("poll1", 8'h20, 1);
        poll_window("poll2", 8'h20, 0);
        csr_model = 8'hA0;
        poll_window("poll3", 8'hA0, 1);
        poll_en = 1'b0;

        // init_req and a DATA read in the same clock.
        wait_rdy(0);
        chk("pre_init_csrq", {24'd0, csrq0}, 32'hA0);
        init_req = 1'b1; cmd_valid0 = 1'b1; cmd_we = 1'b0; cmd_sel = 1'b1;
        step();
        init_req = 1'b0; cmd_valid0 = 1'b0;
        init_cnt = 0; rdy_cnt = 0; rsp_cnt = 0; chg_cnt = 0; got_rdata = 8'h00;
        for (int k = 1; k <= 19; k++) begin
            if (!ninit0 && k <= 8) init_cnt++;
            if (!ninit0 && k > 8) init_cnt += 100;
            if (rdy0 && k <= 18) rdy_cnt++;
            if (rspv0) begin rsp_cnt++; got_rdata = rdata0; end
            if (chg0) chg_cnt++;
            if (k == 9) chk("init_csrq_clr", {24'd0, csrq0}, 0);
            if (k < 19) step();
        end
        chk("init_low_clks", init_cnt, 8);
        chk("init_ready_low", rdy_cnt, 0);
        chk("init_cmd_rsp", rsp_cnt, 1);
        chk("init_cmd_rdata", {24'd0, got_rdata}, 32'h3C);
        chk("init_no_chg", chg_cnt, 0);
        chk("init_ready_back", {31'd0, rdy0}, 1);

        // Reset asserted during the read strobe.
        csr_model = 8'h80;
        cmd_valid0 = 1'b1; cmd_we = 1'b0; cmd_sel = 1'b0;
        step();
        cmd_valid0 = 1'b0;
        step(); step(); step(); step();
        chk("mid_rd_active", {30'd0, nrd0, nsync0}, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_strobes", {28'd0, nrd0, nww0, nsync0, ninit0}, 32'hF);
        chk("mid_bus", {24'd0, nadp0}, 32'hFF);
        chk("mid_busy_rsp", {30'd0, busy0, rspv0}, 0);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (rspv0) rsp_cnt++;
            if (busy0) busy_cnt++;
        end
        chk("mid_after_rsp", rsp_cnt, 0);
        chk("mid_after_busy", busy_cnt, 0);
        chk("mid_after_ready", {31'd0, rdy0}, 1);

        // Minimum timing: write DATA 8'h11.
        wait_rdy(1);
        cmd_valid1 = 1'b1; cmd_we = 1'b1; cmd_sel = 1'b1; cmd_wdata = 8'h11;
        step();
        cmd_valid1 = 1'b0;
        busy_cnt = 0; ww_cnt = 0; ww_ok = 0;
        first_s = 0; last_s = 0; first_w = 0; last_w = 0;
        for (int k = 1; k <= 8; k++) begin
            if (busy1) busy_cnt++;
            if (!nsync1) begin if (first_s == 0) first_s = k; last_s = k; end
            if (!nww1) begin ww_cnt++; if (first_w == 0) first_w = k; last_w = k; end
            if (!nww1 && nadp1 == 8'hEE) ww_ok++;
            if (k == 7) chk("min_ready_back", {31'd0, rdy1}, 1);
            if (k < 8) step();
        end
        chk("min_busy_clks", busy_cnt, 6);
        chk("min_strb_clks", ww_cnt, 1);
        chk("min_strb_data", ww_ok, 1);
        chk("min_sync_first", first_s, 2);
        chk("min_strb_first", first_w, 4);
        chk("min_sync_last", last_s, 5);
        chk("min_sync_cover", {31'd0, (first_s < first_w) && (last_s > last_w)}, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
